mm: RTL and testbench

//  Mealy-style serial run detector. Watches a 1-bit stream (din), one bit per enabled clock.

---
 rtl/mm_pkg.sv | 100 ++++++++++
 rtl/mm.sv | 60 ++++++
 tb/tb_mm.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mm_pkg.sv
// Package for the mm serial run detector: state encoding, the per-bit
// step result record, and the next-state/output helper functions.
package mm_pkg;

    // Encoding is fixed; values 5..7 are illegal and recovered to IDLE.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ONE0 = 3'd1,
        TWO0 = 3'd2,
        ONE1 = 3'd3,
        TWO1 = 3'd4
    } state_t;

    // Result of consuming one bit: where to go and what to flag.
    typedef struct packed {
        state_t nxt;
        logic   x;
        logic   y;
    } step_t;

    // True for the five encodings the detector can legitimately occupy.
    function automatic logic mm_state_legal(input state_t cur);
        logic ok;
        case (cur)
            IDLE, ONE0, TWO0, ONE1, TWO1: ok = 1'b1;
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

    // One enabled step of the detector. 'overlap' selects whether a
    // third equal bit keeps the run alive (TWOb) or restarts the search.
    function automatic step_t mm_step(input state_t cur,
                                      input logic   bit_in,
                                      input logic   overlap);
        step_t r;
        r.nxt = IDLE;
        r.x   = 1'b0;
        r.y   = 1'b0;
        case (cur)
            IDLE: begin
                if (bit_in) begin
                    r.nxt = ONE1;
                end else begin
                    r.nxt = ONE0;
                end
            end
            ONE0: begin
                if (!bit_in) begin
                    r.nxt = TWO0;
                    r.x   = 1'b1;
                end else begin
                    r.nxt = ONE1;
                end
            end
            TWO0: begin
                if (!bit_in) begin
                    if (overlap) begin
                        r.nxt = TWO0;
                    end else begin
                        r.nxt = IDLE;
                    end
                    r.x = 1'b1;
                    r.y = 1'b1;
                end else begin
                    r.nxt = ONE1;
                end
            end
            ONE1: begin
                if (bit_in) begin
                    r.nxt = TWO1;
                    r.x   = 1'b1;
                end else begin
                    r.nxt = ONE0;
                end
            end
            TWO1: begin
                if (bit_in) begin
                    if (overlap) begin
                        r.nxt = TWO1;
                    end else begin
                        r.nxt = IDLE;
                    end
                    r.x = 1'b1;
                    r.y = 1'b1;
                end else begin
                    r.nxt = ONE0;
                end
            end
            default: begin
                // Illegal encoding: no flags, fall back to IDLE.
                r.nxt = IDLE;
                r.x   = 1'b0;
                r.y   = 1'b0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mm.sv
// mm: Mealy serial run detector. doutx flags a run of 2 equal bits,
// douty a run of 3. Optional build macro MM_OVERLAP_EN switches from
// non-overlapping (restart after a 3-run) to overlapping detection.
module mm
    import mm_pkg::*;
(
    input  logic clk,
    input  logic resetn,   // active-high asynchronous reset (legacy name)
    input  logic cen,
    input  logic din,
    output logic doutx,
    output logic douty
);

`ifdef MM_OVERLAP_EN
    localparam logic OVERLAP_EN = 1'b1;
`else
    localparam logic OVERLAP_EN = 1'b0;
`endif

    state_t state_q;
    state_t state_d;
    step_t  step_s;
    logic   x_s;
    logic   y_s;

    // Next state and Mealy outputs from (state, din, cen, reset).
    always_comb begin
        step_s  = mm_step(state_q, din, OVERLAP_EN);
        state_d = state_q;
        x_s     = 1'b0;
        y_s     = 1'b0;
        if (resetn) begin
            // Outputs held low for the whole reset window.
            state_d = IDLE;
        end else if (!mm_state_legal(state_q)) begin
            // Recover from a corrupted encoding even when cen is low.
            state_d = IDLE;
        end else if (cen) begin
            state_d = step_s.nxt;
            x_s     = step_s.x;
            y_s     = step_s.y;
        end else begin
            state_d = state_q;
        end
    end

    // State register with asynchronous active-high reset to IDLE.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign doutx = x_s;
    assign douty = y_s;

endmodule

// File: tb/tb_mm.sv
// Self-checking bench for mm: scoreboard queue of expected {x,y} pairs.
module tb_mm;

    logic clk;
    logic resetn;
    logic cen;
    logic din;
    logic doutx;
    logic douty;

    int n_vec;
    int n_err;
    logic [1:0] sb_q[$];

`ifdef MM_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    mm dut (
        .clk    (clk),
        .resetn (resetn),
        .cen    (cen),
        .din    (din),
        .doutx  (doutx),
        .douty  (douty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one bit at the falling edge, record expectation, settle.
    task automatic drive(input logic c, input logic d, input logic [1:0] e);
        @(negedge clk);
        cen = c;
        din = d;
        sb_q.push_back(e);
        #1;
    endtask

    // Put the DUT back in IDLE, leaving cen low across the release edge.
    task automatic apply_reset();
        @(negedge clk);
        resetn = 1'b1;
        cen    = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
    endtask

    task automatic test_reset();
        logic [1:0] exp;
        // Outputs low while reset is held, even with an enabled bit.
        drive(1'b1, 1'b1, 2'b00);
        exp = sb_q.pop_front(); n_vec++;
        if ({doutx, douty} !== exp) begin
            n_err++; $display("FAIL reset_hold: got %b expected %b", {doutx, douty}, exp);
        end
        cen = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        drive(1'b1, 1'b0, 2'b00);
        exp = sb_q.pop_front(); n_vec++;
        if ({doutx, douty} !== exp) begin
            n_err++; $display("FAIL reset_first0: got %b expected %b", {doutx, douty}, exp);
        end
        drive(1'b1, 1'b0, 2'b10);
        exp = sb_q.pop_front(); n_vec++;
        if ({doutx, douty} !== exp) begin
            n_err++; $display("FAIL reset_second0: got %b expected %b", {doutx, douty}, exp);
        end
        // Now in TWO0: a third 0 would give 11; async reset must mask it.
        drive(1'b1, 1'b0, 2'b11);
        exp = sb_q.pop_front(); n_vec++;
        if ({doutx, douty} !== exp) begin
            n_err++; $display("FAIL reset_pre: got %b expected %b", {doutx, douty}, exp);
        end
        resetn = 1'b1;
        sb_q.push_back(2'b00);
        #1;
        exp = sb_q.pop_front(); n_vec++;
        if ({doutx, douty} !== exp) begin
            n_err++; $display("FAIL reset_async: got %b expected %b", {doutx, douty}, exp);
        end
        cen = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        drive(1'b1, 1'b0, 2'b00);
        exp = sb_q.pop_front(); n_vec++;
        if ({doutx, douty} !== exp) begin
            n_err++; $display("FAIL reset_after: got %b expected %b", {doutx, douty}, exp);
        end
    endtask

    task automatic test_example();
        logic [10:0] dv;
        logic [10:0] xv;
        logic [10:0] yv;
        logic [1:0]  exp;
        dv = 11'b00001110110;
        if (OVL) begin
            xv = 11'b01110110010;
            yv = 11'b00110010000;
        end else begin
            xv = 11'b01100110010;
            yv = 11'b00100010000;
        end
        apply_reset();
        for (int i = 10; i >= 0; i--) begin
            drive(1'b1, dv[i], {xv[i], yv[i]});
            exp = sb_q.pop_front(); n_vec++;
            if ({doutx, douty} !== exp) begin
                n_err++; $display("FAIL example[%0d]: got %b expected %b", 10 - i, {doutx, douty}, exp);
            end
        end
    endtask

    task automatic test_alternating();
        logic [1:0] exp;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, i[0], 2'b00);
            exp = sb_q.pop_front(); n_vec++;
            if ({doutx, douty} !== exp) begin
                n_err++; $display("FAIL alternating[%0d]: got %b expected %b", i, {doutx, douty}, exp);
            end
        end
    endtask

    task automatic test_cen();
        logic [5:0] cv;
        logic [5:0] dv;
        logic [5:0] xv;
        logic [5:0] yv;
        logic [1:0] exp;
        cv = 6'b110001;
        dv = 6'b001010;
        xv = 6'b010001;
        yv = 6'b000001;
        apply_reset();
        for (int i = 5; i >= 0; i--) begin
            drive(cv[i], dv[i], {xv[i], yv[i]});
            exp = sb_q.pop_front(); n_vec++;
            if ({doutx, douty} !== exp) begin
                n_err++; $display("FAIL cen[%0d]: got %b expected %b", 5 - i, {doutx, douty}, exp);
            end
        end
    endtask

    task automatic test_ones_run();
        logic [4:0] xv;
        logic [4:0] yv;
        logic [1:0] exp;
        if (OVL) begin
            xv = 5'b01111;
            yv = 5'b00111;
        end else begin
            xv = 5'b01101;
            yv = 5'b00100;
        end
        apply_reset();
        for (int i = 4; i >= 0; i--) begin
            drive(1'b1, 1'b1, {xv[i], yv[i]});
            exp = sb_q.pop_front(); n_vec++;
            if ({doutx, douty} !== exp) begin
                n_err++; $display("FAIL ones_run[%0d]: got %b expected %b", 4 - i, {doutx, douty}, exp);
            end
        end
    endtask

    task automatic test_reset_in_two1();
        logic [1:0] exp;
        apply_reset();
        drive(1'b1, 1'b1, 2'b00);
        exp = sb_q.pop_front(); n_vec++;
        if ({doutx, douty} !== exp) begin
            n_err++; $display("FAIL two1_a: got %b expected %b", {doutx, douty}, exp);
        end
        drive(1'b1, 1'b1, 2'b10);
        exp = sb_q.pop_front(); n_vec++;
        if ({doutx, douty} !== exp) begin
            n_err++; $display("FAIL two1_b: got %b expected %b", {doutx, douty}, exp);
        end
        resetn = 1'b1;
        cen    = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        drive(1'b1, 1'b1, 2'b00);
        exp = sb_q.pop_front(); n_vec++;
        if ({doutx, douty} !== exp) begin
            n_err++; $display("FAIL two1_cleared: got %b expected %b", {doutx, douty}, exp);
        end
        drive(1'b1, 1'b1, 2'b10);
        exp = sb_q.pop_front(); n_vec++;
        if ({doutx, douty} !== exp) begin
            n_err++; $display("FAIL two1_rebuild: got %b expected %b", {doutx, douty}, exp);
        end
    endtask

    // Random stream checked against a run-length model.
    task automatic test_back_to_back();
        int         run_len;
        logic       last_bit;
        logic       c;
        logic       d;
        logic [1:0] e;
        logic [1:0] exp;
        run_len  = 0;
        last_bit = 1'b0;
        apply_reset();
        for (int i = 0; i < 80; i++) begin
            c = ($urandom_range(0, 3) != 0);
            d = 1'($urandom_range(0, 1));
            e = 2'b00;
            if (c) begin
                if (run_len > 0 && d == last_bit) begin
                    run_len++;
                end else begin
                    run_len = 1;
                end
                last_bit = d;
                e[1] = (run_len >= 2);
                e[0] = OVL ? (run_len >= 3) : (run_len == 3);
                if (!OVL && run_len == 3) run_len = 0;
            end
            drive(c, d, e);
            exp = sb_q.pop_front(); n_vec++;
            if ({doutx, douty} !== exp) begin
                n_err++; $display("FAIL random[%0d] cen=%b din=%b: got %b expected %b", i, c, d, {doutx, douty}, exp);
            end
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        resetn = 1'b1;
        cen    = 1'b0;
        din    = 1'b0;
        test_reset();
        test_example();
        test_alternating();
        test_cen();
        test_ones_run();
        test_reset_in_two1();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
